// File: rtl/sr_latch_ctrl.sv
// Round-robin set/clear controller for a shared NAND SR latch status flag.
// Optional feature macro: SR_READBACK_EN (flag/err follow the sampled latch q_in).
module sr_latch_ctrl #(
    parameter int N_REQ   = 4,
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 1,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] set_req,
    input  logic [N_REQ-1:0] clr_req,
    output logic [N_REQ-1:0] grant,
    output logic             busy,
    output logic             done,
    output logic             s_n,
    output logic             r_n,
    input  logic             q_in,
    output logic             flag,
    output logic             err
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2,
        ST_CHECK = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               op_set_q, op_set_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               s_n_q, s_n_d;
    logic               r_n_q, r_n_d;
    logic               flag_q, flag_d;
    logic               err_q, err_d;

    logic [N_REQ-1:0]   active_s;
    logic               found_s;
    logic [PTR_W-1:0]   win_s;
    logic [PTR_W-1:0]   cand_s;
    logic               op_set_s;

`ifndef SR_READBACK_EN
    logic unused_q_in;
    assign unused_q_in = q_in;
`endif

    // Rotating priority search: first active requester at or above the pointer wins.
    always_comb begin
        active_s = set_req | clr_req;
        found_s  = 1'b0;
        win_s    = {PTR_W{1'b0}};
        cand_s   = {PTR_W{1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            cand_s = PTR_W'((int'(ptr_q) + k) % N_REQ);
            if (!found_s && active_s[cand_s]) begin
                found_s = 1'b1;
                win_s   = cand_s;
            end else begin
                found_s = found_s;
            end
        end
        op_set_s = ~clr_req[win_s];
    end

    // Next-state logic; latch inputs default high so only one can ever be driven low.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        op_set_d = op_set_q;
        grant_d  = {N_REQ{1'b0}};
        done_d   = 1'b0;
        s_n_d    = 1'b1;
        r_n_d    = 1'b1;
        flag_d   = flag_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    state_d  = ST_PULSE;
                    grant_d  = N_REQ'(1) << win_s;
                    ptr_d    = PTR_W'((int'(win_s) + 1) % N_REQ);
                    op_set_d = op_set_s;
                    s_n_d    = ~op_set_s;
                    r_n_d    = op_set_s;
                    cnt_d    = CNT_W'(PULSE_W - 1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PULSE: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = ST_GAP;
                    cnt_d   = CNT_W'(GAP_W - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    s_n_d = ~op_set_q;
                    r_n_d = op_set_q;
                end
            end
            ST_GAP: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = ST_CHECK;
                    done_d  = 1'b1;
`ifdef SR_READBACK_EN
                    flag_d = q_in;
                    if (q_in != op_set_q) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
`else
                    flag_d = op_set_q;
                    err_d  = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            ptr_q    <= {PTR_W{1'b0}};
            op_set_q <= 1'b0;
            grant_q  <= {N_REQ{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            s_n_q    <= 1'b1;
            r_n_q    <= 1'b1;
            flag_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            op_set_q <= op_set_d;
            grant_q  <= grant_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            s_n_q    <= s_n_d;
            r_n_q    <= r_n_d;
            flag_q   <= flag_d;
            err_q    <= err_d;
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign s_n   = s_n_q;
    assign r_n   = r_n_q;
    assign flag  = flag_q;
    assign err   = err_q;

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Directed bench for sr_latch_ctrl with a NAND SR latch model (optionally stuck at 0).
// Expectations for flag/err follow SR_READBACK_EN when it is defined.
module tb_sr_latch_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] set_req = 4'b0000;
    logic [3:0] clr_req = 4'b0000;
    logic [3:0] grant;
    logic       busy, done, s_n, r_n, q_in, flag, err;

    logic latch_q = 1'b0;
    logic stuck0  = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    sr_latch_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .set_req (set_req),
        .clr_req (clr_req),
        .grant   (grant),
        .busy    (busy),
        .done    (done),
        .s_n     (s_n),
        .r_n     (r_n),
        .q_in    (q_in),
        .flag    (flag),
        .err     (err)
    );

    always #5 clk = ~clk;

    always @(s_n or r_n) begin
        if (!s_n) latch_q = 1'b1;
        else if (!r_n) latch_q = 1'b0;
    end
    assign q_in = stuck0 ? 1'b0 : latch_q;

    // Forbidden latch input combination must never appear.
    always @(negedge clk) begin
        vectors++;
        assert (!(~s_n & ~r_n)) else begin
            miscompares++;
            $error("FAIL forbidden_sr observed s_n=%0b r_n=%0b expected not both 0", s_n, r_n);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    logic exp_flag_stuck;
    logic exp_err_stuck;
    logic [3:0] exp_grant;

    initial begin
`ifdef SR_READBACK_EN
        exp_flag_stuck = 1'b0;
        exp_err_stuck  = 1'b1;
`else
        exp_flag_stuck = 1'b1;
        exp_err_stuck  = 1'b0;
`endif
        // reset state
        tick(); tick();
        chk("rst_grant", 8'(grant), 8'h0);
        chk("rst_busy", 8'(busy), 8'h0);
        chk("rst_done", 8'(done), 8'h0);
        chk("rst_s_n", 8'(s_n), 8'h1);
        chk("rst_r_n", 8'(r_n), 8'h1);
        chk("rst_flag", 8'(flag), 8'h0);
        chk("rst_err", 8'(err), 8'h0);

        // single set from requester 0
        rst = 1'b0;
        set_req = 4'b0001;
        tick();
        chk("set_c1_grant", 8'(grant), 8'h1);
        chk("set_c1_s_n", 8'(s_n), 8'h0);
        chk("set_c1_r_n", 8'(r_n), 8'h1);
        chk("set_c1_busy", 8'(busy), 8'h1);
        set_req = 4'b0000;
        tick();
        chk("set_c2_grant", 8'(grant), 8'h0);
        chk("set_c2_s_n", 8'(s_n), 8'h0);
        tick();
        chk("set_c3_s_n", 8'(s_n), 8'h1);
        chk("set_c3_r_n", 8'(r_n), 8'h1);
        chk("set_c3_done", 8'(done), 8'h0);
        tick();
        chk("set_c4_done", 8'(done), 8'h1);
        chk("set_c4_flag", 8'(flag), 8'h1);
        chk("set_c4_err", 8'(err), 8'h0);
        chk("set_c4_busy", 8'(busy), 8'h1);
        tick();
        chk("set_c5_done", 8'(done), 8'h0);
        chk("set_c5_busy", 8'(busy), 8'h0);

        // round-robin with requesters 0 and 2 held, pointer reset to 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req = 4'b0101;
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (c == 1 || c == 11) exp_grant = 4'b0001;
            else if (c == 6) exp_grant = 4'b0100;
            else exp_grant = 4'b0000;
            chk($sformatf("rr_grant_c%0d", c), 8'(grant), 8'(exp_grant));
        end
        set_req = 4'b0000;
        for (int c = 0; c < 4; c++) tick();
        chk("rr_idle_busy", 8'(busy), 8'h0);

        // set and clear together on requester 2: clear wins (pointer is 1)
        set_req = 4'b0100;
        clr_req = 4'b0100;
        tick();
        chk("both_c1_grant", 8'(grant), 8'h4);
        chk("both_c1_r_n", 8'(r_n), 8'h0);
        chk("both_c1_s_n", 8'(s_n), 8'h1);
        set_req = 4'b0000;
        clr_req = 4'b0000;
        tick();
        chk("both_c2_r_n", 8'(r_n), 8'h0);
        chk("both_c2_s_n", 8'(s_n), 8'h1);
        tick();
        chk("both_c3_r_n", 8'(r_n), 8'h1);
        chk("both_c3_s_n", 8'(s_n), 8'h1);
        tick();
        chk("both_c4_done", 8'(done), 8'h1);
        chk("both_c4_flag", 8'(flag), 8'h0);
        chk("both_c4_err", 8'(err), 8'h0);
        tick();

        // reset while s_n is low (pointer 3 wraps to requester 0)
        set_req = 4'b0001;
        tick();
        chk("mid_c1_grant", 8'(grant), 8'h1);
        chk("mid_c1_s_n", 8'(s_n), 8'h0);
        rst = 1'b1;
        set_req = 4'b0000;
        tick();
        chk("mid_rst_s_n", 8'(s_n), 8'h1);
        chk("mid_rst_r_n", 8'(r_n), 8'h1);
        chk("mid_rst_busy", 8'(busy), 8'h0);
        chk("mid_rst_done", 8'(done), 8'h0);
        chk("mid_rst_flag", 8'(flag), 8'h0);
        rst = 1'b0;
        tick();
        chk("mid_after_done", 8'(done), 8'h0);
        chk("mid_after_busy", 8'(busy), 8'h0);

        // set with latch stuck at 0
        stuck0 = 1'b1;
        set_req = 4'b0001;
        tick();
        chk("stk_c1_grant", 8'(grant), 8'h1);
        set_req = 4'b0000;
        tick(); tick(); tick();
        chk("stk_c4_done", 8'(done), 8'h1);
        chk("stk_c4_flag", 8'(flag), 8'(exp_flag_stuck));
        chk("stk_c4_err", 8'(err), 8'(exp_err_stuck));
        tick();

        // later successful clear: err stays sticky when readback is enabled
        stuck0 = 1'b0;
        clr_req = 4'b0001;
        tick();
        chk("clr_c1_grant", 8'(grant), 8'h1);
        chk("clr_c1_r_n", 8'(r_n), 8'h0);
        clr_req = 4'b0000;
        tick(); tick(); tick();
        chk("clr_c4_done", 8'(done), 8'h1);
        chk("clr_c4_flag", 8'(flag), 8'h0);
        chk("clr_c4_err", 8'(err), 8'(exp_err_stuck));
        tick();
        rst = 1'b1;
        tick();
        chk("final_rst_err", 8'(err), 8'h0);
        chk("final_rst_flag", 8'(flag), 8'h0);
        rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
